count_arbiter: RTL and testbench

COUNT_ARBITER -- requirements
Module: count_arbiter

---
 rtl/count_arbiter.sv | 119 +++++++++++
 tb/tb_count_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/count_arbiter.sv
// Two-requester round-robin arbiter time-sharing one pattern detector with per-requester saved context.
// Latency: ready is combinational; hit/hit_id registered one cycle after the accepting edge.
// Backpressure: at most one symbol accepted per cycle; the loser sees ready=0 and holds. Counters: COUNT_ARBITER_HIT_COUNT_EN.
`timescale 1ns/1ps
module count_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic [1:0] req0_num,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_num,
    output logic       req1_ready,
    input  logic       clr0,
    input  logic       clr1,
    output logic       hit,
    output logic       hit_id
`ifdef COUNT_ARBITER_HIT_COUNT_EN
    ,
    output logic [7:0] hit_cnt0,
    output logic [7:0] hit_cnt1
`endif
);

    typedef enum logic [1:0] {S0, S1, S2, S3} state_t;

    state_t     ctx0, ctx1, cur, nxt;
    logic       prio;
    logic       acc, gnt_id, clr_g, hit_nxt;
    logic [1:0] sym;

    // prio names the requester that wins when both are valid
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!reset) begin
            if (req0_valid && (!req1_valid || !prio))
                req0_ready = 1'b1;
            else if (req1_valid)
                req1_ready = 1'b1;
        end
    end

    assign acc    = req0_ready | req1_ready;
    assign gnt_id = req1_ready;
    assign cur    = gnt_id ? ctx1 : ctx0;
    assign sym    = gnt_id ? req1_num : req0_num;
    assign clr_g  = gnt_id ? clr1 : clr0;

    always_comb begin
        nxt = S0;
        case (cur)
            S0: nxt = (sym == 2'd1) ? S1 : S0;
            S1: begin
                if (sym == 2'd1)      nxt = S1;
                else if (sym == 2'd2) nxt = S2;
                else                  nxt = S0;
            end
            S2: begin
                if (sym == 2'd1)      nxt = S1;
                else if (sym == 2'd2) nxt = S2;
                else                  nxt = S3;
            end
            S3: begin
                if (sym == 2'd3)      nxt = S3;
                else if (sym == 2'd1) nxt = S1;
                else                  nxt = S0;
            end
            default: nxt = S0;
        endcase
    end

    // a clear on the granted requester still consumes the symbol but suppresses its hit
    assign hit_nxt = acc && !clr_g && (nxt == S3);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctx0   <= S0;
            ctx1   <= S0;
            prio   <= 1'b0;
            hit    <= 1'b0;
            hit_id <= 1'b0;
        end else begin
            if (acc)
                prio <= ~gnt_id;
            if (acc && !gnt_id)
                ctx0 <= nxt;
            if (acc && gnt_id)
                ctx1 <= nxt;
            if (clr0)
                ctx0 <= S0;
            if (clr1)
                ctx1 <= S0;
            hit <= hit_nxt;
            if (hit_nxt)
                hit_id <= gnt_id;
        end
    end

`ifdef COUNT_ARBITER_HIT_COUNT_EN
    // saturating per-requester hit counters
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt0 <= 8'd0;
            hit_cnt1 <= 8'd0;
        end else begin
            if (clr0)
                hit_cnt0 <= 8'd0;
            else if (hit_nxt && !gnt_id && hit_cnt0 != 8'hff)
                hit_cnt0 <= hit_cnt0 + 8'd1;
            if (clr1)
                hit_cnt1 <= 8'd0;
            else if (hit_nxt && gnt_id && hit_cnt1 != 8'hff)
                hit_cnt1 <= hit_cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_count_arbiter.sv
// Randomized and directed bench for count_arbiter against a table-driven reference model.
`timescale 1ns/1ps
module tb_count_arbiter;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [1:0] req0_num = 2'd0, req1_num = 2'd0;
    logic       req0_ready, req1_ready;
    logic       clr0 = 1'b0, clr1 = 1'b0;
    logic       hit, hit_id;
`ifdef COUNT_ARBITER_HIT_COUNT_EN
    logic [7:0] hit_cnt0, hit_cnt1;
`endif

    always #5 clk = ~clk;

    count_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_num   (req0_num),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_num   (req1_num),
        .req1_ready (req1_ready),
        .clr0       (clr0),
        .clr1       (clr1),
        .hit        (hit),
        .hit_id     (hit_id)
`ifdef COUNT_ARBITER_HIT_COUNT_EN
        ,
        .hit_cnt0   (hit_cnt0),
        .hit_cnt1   (hit_cnt1)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int hits_seen = 0;

    // reference model: next state = tbl[state][symbol]
    int tbl [4][4];
    int m_ctx [2];
    int m_cnt [2];
    int m_prio, m_hit, m_hit_id;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit v0, input bit [1:0] n0, input bit v1, input bit [1:0] n1,
                        input bit c0, input bit c1, input bit rs);
        int g;
        int ns;
        bit v [2];
        int n [2];
        bit c [2];
        v[0] = v0; v[1] = v1; n[0] = n0; n[1] = n1; c[0] = c0; c[1] = c1;
        @(negedge clk);
        req0_valid = v0; req0_num = n0; req1_valid = v1; req1_num = n1;
        clr0 = c0; clr1 = c1; reset = rs;
        #1;
        g = -1;
        if (!rs) begin
            if (v0 && v1) g = m_prio;
            else if (v0)  g = 0;
            else if (v1)  g = 1;
        end
        check("ready0", req0_ready, g == 0);
        check("ready1", req1_ready, g == 1);
        if (rs) begin
            m_ctx[0] = 0; m_ctx[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
            m_prio = 0; m_hit = 0; m_hit_id = 0;
        end else begin
            m_hit = 0;
            if (g >= 0) begin
                m_prio = 1 - g;
                ns = tbl[m_ctx[g]][n[g]];
                if (!c[g]) begin
                    m_ctx[g] = ns;
                    if (ns == 3) begin
                        m_hit = 1;
                        m_hit_id = g;
                        if (m_cnt[g] < 255) m_cnt[g]++;
                    end
                end
            end
            for (int i = 0; i < 2; i++)
                if (c[i]) begin
                    m_ctx[i] = 0;
                    m_cnt[i] = 0;
                end
        end
        @(posedge clk);
        #1;
        check("hit", hit, m_hit);
        check("hit_id", hit_id, m_hit_id);
`ifdef COUNT_ARBITER_HIT_COUNT_EN
        check("hit_cnt0", hit_cnt0, m_cnt[0]);
        check("hit_cnt1", hit_cnt1, m_cnt[1]);
`endif
        if (hit === 1'b1) hits_seen++;
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        tbl = '{'{0, 1, 0, 0}, '{0, 1, 2, 0}, '{3, 1, 2, 3}, '{0, 1, 0, 3}};
        m_ctx[0] = 0; m_ctx[1] = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        m_prio = 0; m_hit = 0; m_hit_id = 0;

        do_reset();
        check("rst_hit", hit, 0);
        check("rst_hit_id", hit_id, 0);

        // req0 alone: 1,2,0 gives a single hit from requester 0
        hits_seen = 0;
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("seq030_hit", hit, 1);
        check("seq030_id", hit_id, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        check("seq030_count", hits_seen, 1);

        // both valid: grants alternate 0,1,0,1,0,1; losing requester holds its symbol
        do_reset();
        hits_seen = 0;
        step(1, 1, 1, 0, 0, 0, 0);
        step(1, 2, 1, 0, 0, 0, 0);
        step(1, 2, 1, 0, 0, 0, 0);
        step(1, 3, 1, 0, 0, 0, 0);
        step(1, 3, 1, 0, 0, 0, 0);
        check("seq031_id", hit_id, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        check("seq031_count", hits_seen, 1);

        // req1: 1,2,3,3,3 gives three hits
        do_reset();
        hits_seen = 0;
        step(0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 2, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0, 0);
        check("seq032_count", hits_seen, 3);
        check("seq032_id", hit_id, 1);
`ifdef COUNT_ARBITER_HIT_COUNT_EN
        check("seq032_cnt1", hit_cnt1, 3);
`endif

        // clear in the same cycle as the completing symbol: consumed, no hit, context flushed
        do_reset();
        hits_seen = 0;
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        check("seq033_count", hits_seen, 0);

        // reset mid-pattern discards progress
        do_reset();
        hits_seen = 0;
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0);
        check("seq034_count", hits_seen, 0);

        // 300 hits on req0: counter saturates
        do_reset();
        hits_seen = 0;
        step(1, 1, 0, 0, 0, 0, 0);
        step(1, 2, 0, 0, 0, 0, 0);
        for (int i = 0; i < 300; i++)
            step(1, 3, 0, 0, 0, 0, 0);
        check("seq035_count", hits_seen, 300);
`ifdef COUNT_ARBITER_HIT_COUNT_EN
        check("seq035_cnt0", hit_cnt0, 255);
`endif

        // random traffic, occasional clears and resets
        do_reset();
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 23) == 0, $urandom_range(0, 23) == 0,
                 $urandom_range(0, 99) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
